// File: rtl/tpu_pkg.sv
// Shared types and defaults for the tpumac feeder blocks.
package tpu_pkg;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef logic signed [BITS_AB_DEF-1:0] operand_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } feed_state_t;

endpackage

// File: rtl/systolic_a_feeder_if.sv
// Tile-load and west-edge stream signals of the A feeder; master drives tile data and start.
interface systolic_a_feeder_if #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int ROWBITS = $clog2(DIM)
);
   logic                   WrEn;
   logic [ROWBITS-1:0]     Crow;
   logic [DIM*BITS_AB-1:0] Arow;
   logic                   start;
   logic [DIM*BITS_AB-1:0] Aout;
   logic                   en_out;
   logic                   busy;
   logic                   done;

   modport master (
      output WrEn, Crow, Arow, start,
      input  Aout, en_out, busy, done
   );

   modport slave (
      input  WrEn, Crow, Arow, start,
      output Aout, en_out, busy, done
   );
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain that delays one lane by DEPTH cycles; DEPTH=0 is a wire.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int BITS  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] i_d,
   output logic [BITS-1:0] o_q
);

   if (DEPTH == 0) begin : g_wire
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign o_q = i_d;
   end else begin : g_regs
      logic [BITS-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j < DEPTH; j++) r_stage[j] <= '0;
         end else begin
            // NOTE: non-blocking assignments make every stage shift together; blocking ones would collapse the chain.
            r_stage[0] <= i_d;
            for (int j = 1; j < DEPTH; j++) r_stage[j] <= r_stage[j-1];
         end
      end

      assign o_q = r_stage[DEPTH-1];
   end

endmodule

// File: rtl/systolic_a_feeder.sv
// Holds one DIM x DIM A tile and streams it column-by-column, skewed per lane, into the array west edge.
module systolic_a_feeder
   import tpu_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF,
   parameter int ROWBITS = $clog2(DIM)
) (
   input logic                 clk,
   input logic                 rst,
   systolic_a_feeder_if.slave  bus
);

   localparam int CW = $clog2(DIM);

   typedef logic signed [BITS_AB-1:0] lane_t;

   feed_state_t   r_state;
   logic [CW-1:0] r_col;
   lane_t         r_tile    [DIM][DIM];
   lane_t         w_inject  [DIM];
   lane_t         w_delayed [DIM];
   lane_t         r_aout    [DIM];
   logic          r_en;
   logic          r_busy;
   logic          r_fin;
   logic          r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_fin   <= 1'b0;
         r_done  <= 1'b0;
         // NOTE: the tile is cleared on reset so a feed after reset streams a known all-zero tile.
         for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) r_tile[r][k] <= '0;
      end else begin
         // Flags trail the state by one edge to line up with the registered lane outputs.
         r_en   <= (r_state != IDLE);
         r_busy <= (r_state != IDLE);
         r_fin  <= (r_state == DRAIN) && (r_col == CW'(DIM-2));
         r_done <= r_fin;

         case (r_state)
            IDLE: begin
               if (bus.WrEn) begin
                  for (int r = 0; r < DIM; r++)
                     if (bus.Crow == ROWBITS'(r))
                        for (int k = 0; k < DIM; k++)
                           r_tile[r][k] <= lane_t'(bus.Arow[k*BITS_AB +: BITS_AB]);
               end
               if (bus.start) begin
                  r_state <= STREAM;
                  r_col   <= '0;
               end
            end
            STREAM: begin
               if (r_col == CW'(DIM-1)) begin
                  r_state <= DRAIN;
                  r_col   <= '0;
               end else begin
                  r_col <= r_col + CW'(1);
               end
            end
            DRAIN: begin
               if (r_col == CW'(DIM-2)) begin
                  r_state <= IDLE;
                  r_col   <= '0;
               end else begin
                  r_col <= r_col + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < DIM; i++) begin
         // NOTE: default first so no path leaves w_inject unassigned and infers a latch.
         w_inject[i] = '0;
         if (r_state == STREAM) w_inject[i] = r_tile[i][r_col];
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      skew_delay_line #(
         .DEPTH (i),
         .BITS  (BITS_AB)
      ) u_dly (
         .clk (clk),
         .rst (rst),
         .i_d (w_inject[i]),
         .o_q (w_delayed[i])
      );

      assign bus.Aout[i*BITS_AB +: BITS_AB] = r_aout[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIM; i++) r_aout[i] <= '0;
      end else begin
         for (int i = 0; i < DIM; i++) r_aout[i] <= w_delayed[i];
      end
   end

   assign bus.en_out = r_en;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Directed bench for systolic_a_feeder at DIM=4, BITS_AB=8, checking lane skew, flags and tile locking.
module tb_systolic_a_feeder;

   localparam int BITS_AB = 8;
   localparam int DIM     = 4;
   localparam int ROWBITS = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] m_tile [4][4];

   systolic_a_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM), .ROWBITS(ROWBITS)) bus ();

   systolic_a_feeder #(.BITS_AB(BITS_AB), .DIM(DIM), .ROWBITS(ROWBITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_aout(input int f);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++)
         if (f - i >= 0 && f - i <= 3) res[i*8 +: 8] = m_tile[i][f-i];
      return res;
   endfunction

   function automatic logic [31:0] flags();
      return {29'b0, bus.en_out, bus.busy, bus.done};
   endfunction

   task automatic window_cycle(input string tag, input int f);
      step();
      check($sformatf("%s aout f=%0d", tag, f), bus.Aout, exp_aout(f));
      check($sformatf("%s flags f=%0d", tag, f), flags(), 32'b110);
   endtask

   task automatic done_cycle(input string tag);
      step();
      check({tag, " done aout"}, bus.Aout, 32'h0);
      check({tag, " done flags"}, flags(), 32'b001);
   endtask

   task automatic load_counting_tile();
      for (int r = 0; r < 4; r++) begin
         bus.WrEn = 1'b1;
         bus.Crow = 3'(r);
         for (int k = 0; k < 4; k++) begin
            bus.Arow[k*8 +: 8] = 8'(16*r + k);
            m_tile[r][k]       = 8'(16*r + k);
         end
         step();
      end
      bus.WrEn = 1'b0;
   endtask

   initial begin
      bus.WrEn  = 1'b0;
      bus.Crow  = '0;
      bus.Arow  = '0;
      bus.start = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) m_tile[r][k] = 8'h00;

      // Reset and idle
      step();
      step();
      check("reset aout", bus.Aout, 32'h0);
      check("reset flags", flags(), 32'b000);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("idle%0d aout", c), bus.Aout, 32'h0);
         check($sformatf("idle%0d flags", c), flags(), 32'b000);
      end

      // Feed 1: A[i][k] = 16*i+k, with hand-computed spot checks
      load_counting_tile();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) begin
         window_cycle("feed1", f);
         if (f == 0) check("feed1 E1 hand", bus.Aout, 32'h0000_0000);
         if (f == 3) check("feed1 E4 hand", bus.Aout, 32'h3021_1203);
         if (f == 6) check("feed1 E7 hand", bus.Aout, 32'h3300_0000);
      end
      done_cycle("feed1");
      step();
      check("after feed1 flags", flags(), 32'b000);

      // Feed 2: write and start while streaming are both ignored
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) begin
         window_cycle("feed2", f);
         if (f < 4) check($sformatf("feed2 lane0 f=%0d", f), {24'h0, bus.Aout[7:0]}, 32'(f));
         if (f == 0) begin
            bus.WrEn  = 1'b1;
            bus.Crow  = 3'd0;
            bus.Arow  = 32'h7F7F_7F7F;
            bus.start = 1'b1;
         end
         if (f == 1) begin
            bus.WrEn  = 1'b0;
            bus.start = 1'b0;
         end
      end
      done_cycle("feed2");
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("no queued start %0d", c), flags(), 32'b000);
      end

      // Feed 3: write row 2 in the same cycle as start
      bus.WrEn  = 1'b1;
      bus.Crow  = 3'd2;
      bus.Arow  = 32'hFCFD_FEFF;
      bus.start = 1'b1;
      m_tile[2][0] = 8'hFF;
      m_tile[2][1] = 8'hFE;
      m_tile[2][2] = 8'hFD;
      m_tile[2][3] = 8'hFC;
      step();
      bus.WrEn  = 1'b0;
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) begin
         window_cycle("feed3", f);
         if (f >= 2 && f <= 5)
            check($sformatf("feed3 lane2 f=%0d", f), {24'h0, bus.Aout[23:16]}, 32'(8'hFF - 8'(f - 2)));
      end
      done_cycle("feed3");

      // Feed 4: reset mid-stream aborts, clears the tile, and suppresses done
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int f = 0; f < 3; f++) window_cycle("feed4", f);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midreset aout", bus.Aout, 32'h0);
      check("midreset flags", flags(), 32'b000);
      for (int c = 0; c < 6; c++) begin
         step();
         check($sformatf("post-reset quiet %0d", c), flags(), 32'b000);
      end
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) m_tile[r][k] = 8'h00;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) window_cycle("zero tile", f);
      done_cycle("zero tile");

      // Feed 5: out-of-range row write, then back-to-back feeds
      load_counting_tile();
      bus.WrEn = 1'b1;
      bus.Crow = 3'd5;
      bus.Arow = 32'h5555_5555;
      step();
      bus.WrEn  = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) begin
         window_cycle("b2b first", f);
         if (f == 6) bus.start = 1'b1;
      end
      done_cycle("b2b first");
      bus.start = 1'b0;
      for (int f = 0; f < 7; f++) window_cycle("b2b second", f);
      done_cycle("b2b second");
      step();
      check("b2b tail flags", flags(), 32'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
